// File: rtl/cnn_window_gen.sv
// KxK sliding-window generator: raster pixel stream in, one window per output position out,
// with runtime padding (none/zero/edge), stride 1/2, ready/valid on both sides and self-flushing.
module cnn_window_gen #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned K         = 3,
  parameter int unsigned MAX_WIDTH = 64,
  parameter int unsigned DIM_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIM_W-1:0]        img_width,
  input  logic [DIM_W-1:0]        img_height,
  input  logic [1:0]              padding_mode,
  input  logic                    stride2,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic [DIM_W-1:0]        win_row,
  output logic [DIM_W-1:0]        win_col,
  output logic                    win_last,
  output logic                    frame_done,
  output logic                    cfg_err
);
  localparam int unsigned AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned SW   = $clog2(K);
  localparam int unsigned CW   = DIM_W + 3;
  localparam int unsigned HALF = K / 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, ERR} state_t;
  state_t state;

  logic                   armed;
  logic [DIM_W-1:0]       cfg_w, cfg_h;
  logic [1:0]             cfg_mode;
  logic                   cfg_s2;
  logic [DIM_W-1:0]       pix_x, pix_y, nr, nc;
  logic [2*DIM_W-1:0]     pix_cnt;
  logic                   all_out, last_done;
  logic [DATA_W-1:0]      lbuf [K][MAX_WIDTH];

  // In IDLE the first pixel's own config decides everything on that same edge.
  logic                   idle;
  logic [DIM_W-1:0]       e_w, e_h;
  logic [1:0]             e_mode;
  logic                   e_s2, pad_on, zero_mode, edge_mode, cfg_bad;
  logic [CW-1:0]          e_p, span_w, span_h, ow, oh;

  assign idle      = (state == IDLE);
  assign e_w       = idle ? img_width    : cfg_w;
  assign e_h       = idle ? img_height   : cfg_h;
  assign e_mode    = idle ? padding_mode : cfg_mode;
  assign e_s2      = idle ? stride2      : cfg_s2;
  assign zero_mode = (e_mode == 2'b01);
  assign edge_mode = (e_mode == 2'b10);
  assign pad_on    = zero_mode || edge_mode;
  assign e_p       = pad_on ? CW'(HALF) : '0;
  assign cfg_bad   = (e_w == '0) || (e_h == '0) || (32'(e_w) > MAX_WIDTH) ||
                     (!pad_on && ((32'(e_w) < K) || (32'(e_h) < K)));
  assign span_w    = CW'(e_w) + (e_p << 1) - CW'(K);
  assign span_h    = CW'(e_h) + (e_p << 1) - CW'(K);
  assign ow        = (e_s2 ? (span_w >> 1) : span_w) + CW'(1);
  assign oh        = (e_s2 ? (span_h >> 1) : span_h) + CW'(1);

  logic                   acc, px_wrap, last_pix, last_err;
  logic [CW-1:0]          px2, py2;
  logic [2*DIM_W:0]       total_pix;

  assign acc       = in_valid && in_ready;
  assign px_wrap   = (CW'(pix_x) + CW'(1)) == CW'(e_w);
  assign px2       = !acc ? CW'(pix_x) : (px_wrap ? '0 : CW'(pix_x) + CW'(1));
  assign py2       = (acc && px_wrap) ? CW'(pix_y) + CW'(1) : CW'(pix_y);
  assign last_pix  = acc && (py2 == CW'(e_h));
  assign total_pix = (2*DIM_W+1)'(e_w) * (2*DIM_W+1)'(e_h);
  assign last_err  = ({1'b0, pix_cnt} + (2*DIM_W+1)'(1)) >= total_pix;

  // A window is complete once its bottom-right in-image pixel has been accepted.
  logic [CW-1:0]          step_r, step_c, ylr, xlr, ylast, xlast;
  logic                   complete_now, complete_pre, emit_ok, load, slot_free;
  logic                   nc_last, is_last_win, last_hs, fin_hs;

  assign step_r       = e_s2 ? (CW'(nr) << 1) : CW'(nr);
  assign step_c       = e_s2 ? (CW'(nc) << 1) : CW'(nc);
  assign ylr          = step_r + CW'(K-1) - e_p;
  assign xlr          = step_c + CW'(K-1) - e_p;
  assign ylast        = (ylr >= CW'(e_h)) ? CW'(e_h) - CW'(1) : ylr;
  assign xlast        = (xlr >= CW'(e_w)) ? CW'(e_w) - CW'(1) : xlr;
  assign complete_now = (ylast < py2) || ((ylast == py2) && (xlast < px2));
  assign complete_pre = (ylast < CW'(pix_y)) || ((ylast == CW'(pix_y)) && (xlast < CW'(pix_x)));
  assign emit_ok      = !all_out && ((idle && !cfg_bad) || state == ACTIVE || state == FLUSH);
  assign slot_free    = !win_valid || win_ready;
  assign load         = emit_ok && slot_free && complete_now;
  assign nc_last      = (CW'(nc) == ow - CW'(1));
  assign is_last_win  = nc_last && (CW'(nr) == oh - CW'(1));
  assign last_hs      = win_valid && win_ready && win_last;
  assign fin_hs       = last_hs || last_done;

  assign in_ready = armed && (idle || state == ERR ||
                    (state == ACTIVE && !(win_valid && !win_ready) && !(complete_pre && !all_out)));

  logic [SW-1:0]          wslot, sl;
  logic [AW-1:0]          xa;
  logic signed [CW-1:0]   ty, tx, hs, ws;
  logic [CW-1:0]          yu, xu;
  logic                   oor;
  logic [DATA_W-1:0]      px;
  logic [K*K*DATA_W-1:0]  tap_data;

  assign wslot = SW'(CW'(pix_y) % CW'(K));
  assign hs    = $signed(CW'(e_h));
  assign ws    = $signed(CW'(e_w));

  // Taps read the row ring; the pixel accepted this cycle is forwarded straight from in_data.
  always_comb begin
    tap_data = '0;
    ty = '0; tx = '0; yu = '0; xu = '0; sl = '0; xa = '0; oor = 1'b0; px = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        ty  = $signed(step_r) + $signed(CW'(r)) - $signed(e_p);
        tx  = $signed(step_c) + $signed(CW'(c)) - $signed(e_p);
        oor = ty[CW-1] || (ty >= hs) || tx[CW-1] || (tx >= ws);
        if (ty[CW-1])     ty = '0;
        else if (ty >= hs) ty = hs - $signed(CW'(1));
        if (tx[CW-1])     tx = '0;
        else if (tx >= ws) tx = ws - $signed(CW'(1));
        yu = $unsigned(ty);
        xu = $unsigned(tx);
        sl = SW'(yu % CW'(K));
        xa = AW'(xu);
        px = lbuf[sl][xa];
        if (acc && (sl == wslot) && (xa == AW'(pix_x))) px = in_data;
        if (oor && zero_mode) px = '0;
        tap_data[(r*K+c)*DATA_W +: DATA_W] = px;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) lbuf[wslot][AW'(pix_x)] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      cfg_w      <= '0;
      cfg_h      <= '0;
      cfg_mode   <= '0;
      cfg_s2     <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_cnt    <= '0;
      nr         <= '0;
      nc         <= '0;
      all_out    <= 1'b0;
      last_done  <= 1'b0;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      armed      <= 1'b1;
      frame_done <= 1'b0;
      if (acc) begin
        pix_x   <= DIM_W'(px2);
        pix_y   <= DIM_W'(py2);
        pix_cnt <= pix_cnt + (2*DIM_W)'(1);
      end
      if (load) begin
        win_valid <= 1'b1;
        win_data  <= tap_data;
        win_row   <= nr;
        win_col   <= nc;
        win_last  <= is_last_win;
        if (is_last_win) all_out <= 1'b1;
        if (nc_last) begin
          nc <= '0;
          nr <= nr + DIM_W'(1);
        end else begin
          nc <= nc + DIM_W'(1);
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
      // With stride 2 and no padding the last window can finish before the last pixel.
      if (last_hs) last_done <= 1'b1;

      case (state)
        IDLE: if (acc) begin
          cfg_w    <= img_width;
          cfg_h    <= img_height;
          cfg_mode <= padding_mode;
          cfg_s2   <= stride2;
          cfg_err  <= cfg_bad;
          if (cfg_bad) begin
            if (last_err) begin
              frame_done <= 1'b1;
              pix_x <= '0; pix_y <= '0; pix_cnt <= '0;
            end else begin
              state <= ERR;
            end
          end else begin
            state <= last_pix ? FLUSH : ACTIVE;
          end
        end
        ACTIVE: if (last_pix) begin
          if (fin_hs) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            pix_x <= '0; pix_y <= '0; pix_cnt <= '0;
            nr <= '0; nc <= '0; all_out <= 1'b0; last_done <= 1'b0;
          end else begin
            state <= FLUSH;
          end
        end
        FLUSH: if (fin_hs) begin
          state      <= IDLE;
          frame_done <= 1'b1;
          pix_x <= '0; pix_y <= '0; pix_cnt <= '0;
          nr <= '0; nc <= '0; all_out <= 1'b0; last_done <= 1'b0;
        end
        ERR: if (acc && last_err) begin
          state      <= IDLE;
          frame_done <= 1'b1;
          pix_x <= '0; pix_y <= '0; pix_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen (K=3, 8-bit pixels, p(r,c)=r*8+c).
`timescale 1ns/1ps
module tb_cnn_window_gen;
  localparam int WW = 72;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      img_width = 8'd8, img_height = 8'd8;
  logic [1:0]      padding_mode = 2'b01;
  logic            stride2 = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_data = 8'd0;
  logic            win_valid;
  logic            win_ready = 1'b1;
  logic [WW-1:0]   win_data;
  logic [7:0]      win_row, win_col;
  logic            win_last, frame_done, cfg_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rnd_ready = 1'b0;

  cnn_window_gen #(.DATA_W(8), .K(3), .MAX_WIDTH(64), .DIM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .img_width(img_width), .img_height(img_height),
    .padding_mode(padding_mode), .stride2(stride2), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .win_last(win_last), .frame_done(frame_done),
    .cfg_err(cfg_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [WW-1:0] cq_data[$];
  int cq_row[$], cq_col[$], cq_last[$];
  logic [WW-1:0] s1_data[$];
  int acc_cnt = 0, fd_cnt = 0, fd_cyc = -1, hs_cyc = -1;
  logic stall_prev = 1'b0;
  logic [127:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {38'd0, win_valid, win_data, win_row, win_col, win_last}, held);
      if (in_valid && in_ready) acc_cnt++;
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
      if (win_valid && win_ready) begin
        cq_data.push_back(win_data);
        cq_row.push_back(int'(win_row));
        cq_col.push_back(int'(win_col));
        cq_last.push_back(int'(win_last));
        if (win_last) hs_cyc = cyc;
      end
      stall_prev = win_valid && !win_ready;
      held = {38'd0, 1'b1, win_data, win_row, win_col, win_last};
    end
  end

  function automatic logic [WW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [WW-1:0] model(input int orow, ocol, w, h, mode, s2);
    logic [WW-1:0] v;
    int p, s, y, x;
    v = '0;
    p = (mode == 1 || mode == 2) ? 1 : 0;
    s = s2 ? 2 : 1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        y = orow * s - p + r;
        x = ocol * s - p + c;
        if (y < 0 || y >= h || x < 0 || x >= w) begin
          if (mode == 1) begin
            v[(r*3+c)*8 +: 8] = 8'd0;
            continue;
          end
          y = (y < 0) ? 0 : ((y >= h) ? h - 1 : y);
          x = (x < 0) ? 0 : ((x >= w) ? w - 1 : x);
        end
        v[(r*3+c)*8 +: 8] = 8'(y * 8 + x);
      end
    end
    return v;
  endfunction

  task automatic push_pixel(input logic [7:0] v);
    int n;
    n = 0;
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 500) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int w, h, mode, s2, gaps, rnd, maxpix);
    int n;
    cq_data.delete(); cq_row.delete(); cq_col.delete(); cq_last.delete();
    acc_cnt = 0; fd_cnt = 0; fd_cyc = -1; hs_cyc = -1;
    img_width = 8'(w); img_height = 8'(h); padding_mode = 2'(mode); stride2 = 1'(s2);
    rnd_ready = 1'(rnd);
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n < maxpix) begin
          push_pixel(8'(r * 8 + c));
          n++;
          if (gaps) begin
            // config changes mid-frame must be ignored
            img_width = 8'd5; img_height = 8'd3; padding_mode = 2'b10; stride2 = 1'b1;
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          end
        end
      end
    end
    if (maxpix >= w * h) begin
      n = 0;
      while (fd_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
      if (fd_cnt == 0) chk("frame_done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
    end
    rnd_ready = 1'b0;
  endtask

  task automatic sweep(input string tag, input int w, h, mode, s2, ow, oh);
    chk({tag, "_count"}, cq_data.size(), ow * oh);
    for (int i = 0; i < cq_data.size() && i < ow * oh; i++) begin
      chk({tag, "_row"}, cq_row[i], i / ow);
      chk({tag, "_col"}, cq_col[i], i % ow);
      chk({tag, "_data"}, cq_data[i], model(i / ow, i % ow, w, h, mode, s2));
      chk({tag, "_last"}, cq_last[i], (i == ow * oh - 1) ? 1 : 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_data"}, win_data, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_win_last"}, win_last, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 8x8 zero padding, stride 1
    run_frame(8, 8, 1, 0, 0, 0, 64);
    chk("s1_count", cq_data.size(), 64);
    if (cq_data.size() > 0) chk("s1_first", cq_data[0], pk(0, 0, 0, 0, 0, 1, 0, 8, 9));
    if (cq_data.size() == 64) begin
      chk("s1_last_rc", {cq_row[63], cq_col[63]}, {32'd7, 32'd7});
      chk("s1_last_flag", cq_last[63], 1);
    end
    chk("s1_fd_count", fd_cnt, 1);
    chk("s1_fd_timing", fd_cyc, hs_cyc + 1);
    chk("s1_cfg_err", cfg_err, 0);
    sweep("s1", 8, 8, 1, 0, 8, 8);
    s1_data = cq_data;

    // 2: no padding
    run_frame(8, 8, 0, 0, 0, 0, 64);
    chk("s2_count", cq_data.size(), 36);
    if (cq_data.size() > 0) chk("s2_first", cq_data[0], pk(0, 1, 2, 8, 9, 10, 16, 17, 18));
    if (cq_data.size() == 36) chk("s2_last_rc", {cq_row[35], cq_col[35]}, {32'd5, 32'd5});
    sweep("s2", 8, 8, 0, 0, 6, 6);

    // 3: edge replicate
    run_frame(8, 8, 2, 0, 0, 0, 64);
    chk("s3_count", cq_data.size(), 64);
    if (cq_data.size() == 64) begin
      chk("s3_first", cq_data[0], pk(0, 0, 1, 0, 0, 1, 8, 8, 9));
      chk("s3_final", cq_data[63], pk(54, 55, 55, 62, 63, 63, 62, 63, 63));
    end
    sweep("s3", 8, 8, 2, 0, 8, 8);

    // 4: zero padding, stride 2
    run_frame(8, 8, 1, 1, 0, 0, 64);
    chk("s4_count", cq_data.size(), 16);
    if (cq_data.size() == 16) begin
      chk("s4_w11", cq_data[5], pk(9, 10, 11, 17, 18, 19, 25, 26, 27));
      chk("s4_last_rc", {cq_row[15], cq_col[15]}, {32'd3, 32'd3});
    end
    sweep("s4", 8, 8, 1, 1, 4, 4);

    // 5: scenario 1 under random backpressure and input gaps
    run_frame(8, 8, 1, 0, 1, 1, 64);
    chk("s5_count", cq_data.size(), 64);
    for (int i = 0; i < 64 && i < cq_data.size(); i++) chk("s5_seq", cq_data[i], s1_data[i]);
    chk("s5_fd_count", fd_cnt, 1);

    // 6a: illegal config
    run_frame(2, 8, 0, 0, 0, 0, 16);
    chk("s6_cfg_err", cfg_err, 1);
    chk("s6_no_windows", cq_data.size(), 0);
    chk("s6_accepted", acc_cnt, 16);
    chk("s6_fd_count", fd_cnt, 1);

    // 6b: reset mid-frame, then rerun scenario 1
    run_frame(8, 8, 1, 0, 0, 0, 20);
    chk("s6_partial_acc", acc_cnt, 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(8, 8, 1, 0, 0, 0, 64);
    chk("s6_rerun_count", cq_data.size(), 64);
    for (int i = 0; i < 64 && i < cq_data.size(); i++) chk("s6_rerun_seq", cq_data[i], s1_data[i]);
    chk("s6_rerun_fd", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
